// File: rtl/bypass_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : bypass_scoreboard
// Purpose  : Tracks in-flight register writes across STAGES post-decode slots.
//            Forwards operand data from the youngest producing slot to NUM_RD
//            read ports. Raises stall when a producer's result is not yet
//            available (load-use or long latency).
// Options  : BYPASS_SCOREBOARD_STATS_EN adds saturating stall and forward
//            event counters, together with a synchronous clear input.
// Revision : 1.0 - initial release
// ============================================================================
module bypass_scoreboard #(
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    parameter int  STAGES = 3,
    parameter int  NUM_RD = 2,
    parameter int  LW     = $clog2(STAGES + 1),
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iss_valid,
    input  logic                     iss_wen,
    input  logic [AW-1:0]            iss_rd,
    input  logic [LW-1:0]            iss_lat,
    input  logic [NUM_RD*AW-1:0]     iss_rs,
    input  logic [NUM_RD*XLEN-1:0]   rf_rdata,
    input  logic [STAGES*XLEN-1:0]   stage_data,
    input  logic                     hold,
    input  logic [STAGES-1:0]        kill_mask,
`ifdef BYPASS_SCOREBOARD_STATS_EN
    input  logic                     stat_clr,
    output logic [31:0]              stat_stall_cycles,
    output logic [31:0]              stat_fwd_events,
`endif
    output logic                     stall,
    output logic [NUM_RD*XLEN-1:0]   fwd_data,
    output logic [NUM_RD-1:0]        fwd_hit
);

    // Slot state: slot 0 is EX, slot STAGES-1 is WB
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_wen;
    logic [AW-1:0]     r_rd  [STAGES];
    logic [LW-1:0]     r_lat [STAGES];

    logic [STAGES-1:0] w_nxt_valid;
    logic [STAGES-1:0] w_nxt_wen;
    logic [AW-1:0]     w_nxt_rd  [STAGES];
    logic [LW-1:0]     w_nxt_lat [STAGES];

    logic [NUM_RD-1:0] w_hazard;
    logic              w_issue;

    // Per-port match: scan oldest to youngest so the lowest-index slot wins
    always_comb begin
        fwd_data = rf_rdata;
        fwd_hit  = '0;
        w_hazard = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int s = STAGES - 1; s >= 0; s--) begin
                if (r_valid[s] && r_wen[s] &&
                    (r_rd[s] == iss_rs[p*AW +: AW]) &&
                    (iss_rs[p*AW +: AW] != '0)) begin
                    if (s >= int'(r_lat[s])) begin
                        fwd_hit[p]                = 1'b1;
                        w_hazard[p]               = 1'b0;
                        fwd_data[p*XLEN +: XLEN]  = stage_data[s*XLEN +: XLEN];
                    end else begin
                        fwd_hit[p]                = 1'b0;
                        w_hazard[p]               = 1'b1;
                        fwd_data[p*XLEN +: XLEN]  = rf_rdata[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    assign stall   = iss_valid & (|w_hazard);
    assign w_issue = iss_valid & ~stall & ~hold;

    // Next slot state: shift (or freeze on hold), then apply kill on top
    always_comb begin
        w_nxt_valid = r_valid;
        w_nxt_wen   = r_wen;
        for (int s = 0; s < STAGES; s++) begin
            w_nxt_rd[s]  = r_rd[s];
            w_nxt_lat[s] = r_lat[s];
        end
        if (!hold) begin
            w_nxt_valid[0] = w_issue;
            w_nxt_wen[0]   = iss_wen;
            w_nxt_rd[0]    = iss_rd;
            w_nxt_lat[0]   = iss_lat;
            for (int s = 1; s < STAGES; s++) begin
                w_nxt_valid[s] = r_valid[s-1];
                w_nxt_wen[s]   = r_wen[s-1];
                w_nxt_rd[s]    = r_rd[s-1];
                w_nxt_lat[s]   = r_lat[s-1];
            end
        end
        w_nxt_valid = w_nxt_valid & ~kill_mask;
    end

    // Slot registers; reset empties the pipeline immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_wen   <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_rd[s]  <= '0;
                r_lat[s] <= '0;
            end
        end else begin
            r_valid <= w_nxt_valid;
            r_wen   <= w_nxt_wen;
            for (int s = 0; s < STAGES; s++) begin
                r_rd[s]  <= w_nxt_rd[s];
                r_lat[s] <= w_nxt_lat[s];
            end
        end
    end

`ifdef BYPASS_SCOREBOARD_STATS_EN
    logic [31:0] r_stat_stall;
    logic [31:0] r_stat_fwd;
    logic [31:0] w_fwd_cnt;
    logic [32:0] w_fwd_sum;

    // Number of ports served from the pipeline this cycle
    always_comb begin
        w_fwd_cnt = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_fwd_cnt = w_fwd_cnt + 32'(fwd_hit[p]);
        end
    end

    assign w_fwd_sum = {1'b0, r_stat_fwd} + {1'b0, w_fwd_cnt};

    // Saturating event counters with synchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_stall <= '0;
            r_stat_fwd   <= '0;
        end else if (stat_clr) begin
            r_stat_stall <= '0;
            r_stat_fwd   <= '0;
        end else begin
            if (stall && !hold && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
            if (w_issue) begin
                r_stat_fwd <= w_fwd_sum[32] ? '1 : w_fwd_sum[31:0];
            end
        end
    end

    assign stat_stall_cycles = r_stat_stall;
    assign stat_fwd_events   = r_stat_fwd;
`endif

`ifndef SYNTHESIS
    // A latency must name an existing slot, otherwise the result never forwards
    a_lat_legal: assert property (@(posedge clk) disable iff (!rst_n)
        iss_valid |-> (int'(iss_lat) < STAGES));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bypass_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_bypass_scoreboard
// Purpose  : Scenario-driven self-checking bench for bypass_scoreboard.
//            Expected {stall, fwd_hit, fwd_data} vectors are queued while
//            stimulus is driven and popped when the outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bypass_scoreboard;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int STAGES = 3;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;
    localparam int LW     = 2;
    localparam int VW     = 1 + NUM_RD + NUM_RD*XLEN;

    localparam logic [31:0] RF0 = 32'h0000_F000;
    localparam logic [31:0] RF1 = 32'h0000_F001;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     iss_valid = 1'b0;
    logic                     iss_wen = 1'b0;
    logic [AW-1:0]            iss_rd = '0;
    logic [LW-1:0]            iss_lat = '0;
    logic [NUM_RD*AW-1:0]     iss_rs = '0;
    logic [NUM_RD*XLEN-1:0]   rf_rdata = {RF1, RF0};
    logic [STAGES*XLEN-1:0]   stage_data = '0;
    logic                     hold = 1'b0;
    logic [STAGES-1:0]        kill_mask = '0;
    logic                     stall;
    logic [NUM_RD*XLEN-1:0]   fwd_data;
    logic [NUM_RD-1:0]        fwd_hit;
`ifdef BYPASS_SCOREBOARD_STATS_EN
    logic                     stat_clr = 1'b0;
    logic [31:0]              stat_stall_cycles;
    logic [31:0]              stat_fwd_events;
`endif

    logic [VW-1:0] q_exp [$];
    int vectors = 0;
    int miscompares = 0;

    bypass_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .STAGES(STAGES), .NUM_RD(NUM_RD), .LW(LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_valid  (iss_valid),
        .iss_wen    (iss_wen),
        .iss_rd     (iss_rd),
        .iss_lat    (iss_lat),
        .iss_rs     (iss_rs),
        .rf_rdata   (rf_rdata),
        .stage_data (stage_data),
        .hold       (hold),
        .kill_mask  (kill_mask),
`ifdef BYPASS_SCOREBOARD_STATS_EN
        .stat_clr          (stat_clr),
        .stat_stall_cycles (stat_stall_cycles),
        .stat_fwd_events   (stat_fwd_events),
`endif
        .stall      (stall),
        .fwd_data   (fwd_data),
        .fwd_hit    (fwd_hit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] mk(input logic st, input logic [1:0] hit,
                                         input logic [31:0] d1, input logic [31:0] d0);
        return {st, hit, d1, d0};
    endfunction

    task automatic drive(input int v, input int w, input int rd, input int lat,
                         input int rs0, input int rs1, input int h, input int k);
        iss_valid = 1'(v);
        iss_wen   = 1'(w);
        iss_rd    = AW'(rd);
        iss_lat   = LW'(lat);
        iss_rs    = {AW'(rs1), AW'(rs0)};
        hold      = 1'(h);
        kill_mask = STAGES'(k);
    endtask

    // Let the pipeline drain to all-bubble
    task automatic flush();
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (STAGES) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [VW-1:0] e, o;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (i == 0) drive(1, 1, 5, 0, 5, 5, 0, 0);
            else        drive(0, 0, 0, 0, 5, 5, 0, 0);
            q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
            @(negedge clk);
            if (i == 1) rst_n = 1'b1;
            o = {stall, fwd_hit, fwd_data};
            e = q_exp.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset step %0d: got %h want %h", i, o, e);
            end
        end
`ifdef BYPASS_SCOREBOARD_STATS_EN
        vectors++;
        if ({stat_stall_cycles, stat_fwd_events} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_stats: got %h/%h want 0/0", stat_stall_cycles, stat_fwd_events);
        end
`endif
        flush();
    endtask

    task automatic test_alu_chain();
        logic [VW-1:0] e, o;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            case (i)
                0: begin
                    drive(1, 1, 5, 0, 0, 0, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
                end
                1: begin
                    stage_data = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_1234};
                    drive(1, 0, 0, 0, 5, 9, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b01, RF1, 32'h0000_1234));
                end
                default: begin
                    drive(0, 0, 0, 0, 5, 5, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b11, 32'h0000_00C1, 32'h0000_00C1));
                end
            endcase
            @(negedge clk);
            o = {stall, fwd_hit, fwd_data};
            e = q_exp.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL alu_chain step %0d: got %h want %h", i, o, e);
            end
        end
        flush();
    endtask

    task automatic test_load_use();
        logic [VW-1:0] e, o;
        stage_data = {32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            case (i)
                0: begin
                    drive(1, 1, 7, 1, 0, 0, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
                end
                1: begin
                    drive(1, 1, 8, 0, 0, 7, 0, 0);
                    q_exp.push_back(mk(1'b1, 2'b00, RF1, RF0));
                end
                2: begin
                    stage_data = {32'h0000_00D2, 32'hDEAD_BEEF, 32'h0000_00D0};
                    drive(1, 1, 8, 0, 0, 7, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b10, 32'hDEAD_BEEF, RF0));
                end
                default: begin
                    drive(0, 0, 0, 0, 7, 8, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b11, 32'h0000_00D0, 32'h0000_00D2));
                end
            endcase
            @(negedge clk);
            o = {stall, fwd_hit, fwd_data};
            e = q_exp.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL load_use step %0d: got %h want %h", i, o, e);
            end
        end
        flush();
    endtask

    task automatic test_youngest();
        logic [VW-1:0] e, o;
        stage_data = {32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            case (i)
                0: begin
                    drive(1, 1, 3, 0, 0, 0, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
                end
                1: begin
                    drive(1, 1, 4, 0, 0, 0, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
                end
                2: begin
                    drive(1, 1, 3, 0, 3, 0, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b01, RF1, 32'h0000_00A1));
                end
                default: begin
                    stage_data = {32'h0000_AAAA, 32'h0000_4444, 32'h0000_BBBB};
                    drive(0, 0, 0, 0, 3, 4, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b11, 32'h0000_4444, 32'h0000_BBBB));
                end
            endcase
            @(negedge clk);
            o = {stall, fwd_hit, fwd_data};
            e = q_exp.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL youngest step %0d: got %h want %h", i, o, e);
            end
        end
        flush();
    endtask

    task automatic test_x0_and_nowen();
        logic [VW-1:0] e, o;
        stage_data = {32'h0000_0062, 32'h0000_0061, 32'h0000_0060};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            case (i)
                0: begin
                    drive(1, 1, 0, 1, 0, 0, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
                end
                1: begin
                    rf_rdata = '0;
                    drive(1, 0, 6, 0, 0, 0, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b00, 32'h0, 32'h0));
                end
                default: begin
                    rf_rdata = {RF1, RF0};
                    drive(0, 0, 0, 0, 6, 0, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
                end
            endcase
            @(negedge clk);
            o = {stall, fwd_hit, fwd_data};
            e = q_exp.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL x0_nowen step %0d: got %h want %h", i, o, e);
            end
        end
        flush();
    endtask

    task automatic test_hold_kill();
        logic [VW-1:0] e, o;
        stage_data = {32'h0000_00E2, 32'h0000_00E1, 32'h0000_00E0};
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            case (i)
                0, 1, 2: begin
                    drive(1, 1, 10 + i, 0, 0, 0, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
                end
                3, 4, 5: begin
                    drive(1, 1, 13, 0, 10, 12, 1, 0);
                    q_exp.push_back(mk(1'b0, 2'b11, 32'h0000_00E0, 32'h0000_00E2));
                end
                6: begin
                    drive(1, 1, 13, 0, 10, 12, 1, 3);
                    q_exp.push_back(mk(1'b0, 2'b11, 32'h0000_00E0, 32'h0000_00E2));
                end
                7: begin
                    drive(0, 0, 0, 0, 10, 12, 1, 0);
                    q_exp.push_back(mk(1'b0, 2'b01, RF1, 32'h0000_00E2));
                end
                default: begin
                    drive(0, 0, 0, 0, 11, 13, 0, 0);
                    q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
                end
            endcase
            @(negedge clk);
            o = {stall, fwd_hit, fwd_data};
            e = q_exp.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL hold_kill step %0d: got %h want %h", i, o, e);
            end
        end
        flush();
    endtask

    task automatic test_async_reset();
        logic [VW-1:0] e, o;
        stage_data = {32'h0000_00F2, 32'h0000_00F1, 32'h0000_00F0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            case (i)
                0: drive(1, 1, 20, 0, 0, 0, 0, 0);
                1: drive(1, 1, 21, 0, 0, 0, 0, 0);
                2: drive(1, 1, 22, 1, 0, 0, 0, 0);
                3: drive(0, 0, 0, 0, 20, 22, 1, 0);
                default: drive(1, 0, 0, 0, 20, 22, 1, 0);
            endcase
            if (i < 3)       q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
            else if (i == 3) q_exp.push_back(mk(1'b0, 2'b01, RF1, 32'h0000_00F2));
            else             q_exp.push_back(mk(1'b1, 2'b01, RF1, 32'h0000_00F2));
            @(negedge clk);
            o = {stall, fwd_hit, fwd_data};
            e = q_exp.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL async_reset step %0d: got %h want %h", i, o, e);
            end
        end
        // Reset between clock edges must clear slots without waiting for clk
        #2;
        rst_n = 1'b0;
        q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
        #1;
        o = {stall, fwd_hit, fwd_data};
        e = q_exp.pop_front();
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL async_reset immediate: got %h want %h", o, e);
        end
`ifdef BYPASS_SCOREBOARD_STATS_EN
        vectors++;
        if ({stat_stall_cycles, stat_fwd_events} !== 64'd0) begin
            miscompares++;
            $display("FAIL async_reset_stats: got %h/%h want 0/0", stat_stall_cycles, stat_fwd_events);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 20, 22, 0, 0);
        q_exp.push_back(mk(1'b0, 2'b00, RF1, RF0));
        @(negedge clk);
        o = {stall, fwd_hit, fwd_data};
        e = q_exp.pop_front();
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL async_reset after_release: got %h want %h", o, e);
        end
        flush();
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_youngest();
        test_x0_and_nowen();
        test_hold_kill();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
